hs_wb_buffer: RTL and testbench

- Downstream of the hardswish block.
- Captures its 16-lane OUT_SIZE-bit result vectors (one beat per valid cycle, no backpressure available upstream) into a small FIFO.
- Drains the FIFO to the feature-map write port with an auto-incrementing address.
- Runs one tile per start command; signals done when every expected beat has been written to memory.

---
 rtl/hs_wb_buffer_pkg.sv | 21 ++
 rtl/hs_wb_buffer_fifo.sv | 56 +++++
 rtl/hs_wb_buffer.sv | 154 +++++++++++++++
 tb/tb_hs_wb_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_wb_buffer_pkg.sv
// Shared definitions for the hardswish write-back buffer: lane geometry
// defaults, the tile FSM state type and the packed-vector width helper.
package hs_wb_buffer_pkg;

  localparam int unsigned HS_OUT_SIZE = 14;
  localparam int unsigned HS_LANES    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

  // Total bit width of one beat: every lane packed side by side, lane 0 at the LSBs.
  function automatic int unsigned vec_width(input int unsigned out_size,
                                            input int unsigned lanes);
    return out_size * lanes;
  endfunction

endpackage

// File: rtl/hs_wb_buffer_fifo.sv
// hs_wb_fifo: synchronous show-ahead FIFO. The head entry is visible on
// o_rdata whenever o_empty is low; o_level is the registered occupancy.
// The caller must never push when full without popping in the same cycle,
// and never pop when empty.
module hs_wb_fifo
  import hs_wb_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = vec_width(HS_OUT_SIZE, HS_LANES),
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;

endmodule

// File: rtl/hs_wb_buffer.sv
// hs_wb_buffer: captures hardswish result beats into a small FIFO and drains
// them to the feature-map write port at an auto-incrementing address, one
// tile per start command.
// Optional build macro HS_WB_DROP_CNT_EN adds a 16-bit saturating drop_count
// output counting beats lost to a full FIFO in the current tile.
module hs_wb_buffer
  import hs_wb_buffer_pkg::*;
#(
  parameter int unsigned OUT_SIZE   = HS_OUT_SIZE,
  parameter int unsigned LANES      = HS_LANES,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [CNT_WIDTH-1:0]                 num_words,
  input  logic [vec_width(OUT_SIZE,LANES)-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [vec_width(OUT_SIZE,LANES)-1:0] mem_wdata,
  input  logic                                 mem_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level
`ifdef HS_WB_DROP_CNT_EN
  ,
  output logic [15:0]                          drop_count
`endif
);

  localparam int unsigned DW = vec_width(OUT_SIZE, LANES);

  wb_state_t                   r_state;
  logic [CNT_WIDTH-1:0]        r_num;
  logic [CNT_WIDTH-1:0]        r_accepted;
  logic [CNT_WIDTH-1:0]        r_written;
  logic [CNT_WIDTH-1:0]        r_dropped;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic                        r_overflow;

  logic                        w_full;
  logic                        w_empty;
  logic [DW-1:0]               w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;
  logic                        w_wr_en;
  logic                        w_pop;
  logic                        w_push_try;
  logic                        w_push;
  logic                        w_drop;
  logic                        w_start_ok;
  logic [CNT_WIDTH-1:0]        w_acc_nxt;
  logic [CNT_WIDTH-1:0]        w_wr_nxt;
  logic [CNT_WIDTH-1:0]        w_drop_nxt;
  logic [CNT_WIDTH-1:0]        w_fin_nxt;

  hs_wb_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Push/pop arbitration and next counter values. A push into a full FIFO
  // still succeeds when the head leaves in the same cycle; otherwise the
  // beat is dropped but counted as accepted so the tile length stays fixed.
  always_comb begin
    w_wr_en    = !w_empty && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    w_pop      = w_wr_en && mem_ready;
    w_push_try = (r_state == ST_RUN) && in_valid && (r_accepted < r_num);
    w_push     = w_push_try && (!w_full || w_pop);
    w_drop     = w_push_try && !w_push;
    w_start_ok = (r_state == ST_IDLE) && start;
    w_acc_nxt  = r_accepted + CNT_WIDTH'(w_push_try);
    w_wr_nxt   = r_written  + CNT_WIDTH'(w_pop);
    w_drop_nxt = r_dropped  + CNT_WIDTH'(w_drop);
    w_fin_nxt  = w_wr_nxt + w_drop_nxt;
  end

  // Tile FSM, beat counters and write address. Transitions use next counter
  // values so DRAIN is entered right after the last beat and DONE right
  // after the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num      <= '0;
      r_accepted <= '0;
      r_written  <= '0;
      r_dropped  <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_accepted <= w_acc_nxt;
      r_written  <= w_wr_nxt;
      r_dropped  <= w_drop_nxt;
      if (w_pop)  r_addr     <= r_addr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num      <= num_words;
            r_addr     <= base_addr;
            r_accepted <= '0;
            r_written  <= '0;
            r_dropped  <= '0;
            r_overflow <= 1'b0;
            r_state    <= (num_words == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_acc_nxt == r_num) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_fin_nxt == r_num) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HS_WB_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Saturating per-tile count of beats lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                               r_drop_count <= '0;
    else if (w_start_ok)                   r_drop_count <= '0;
    else if (w_drop && r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
  end

  assign drop_count = r_drop_count;
`endif

  assign mem_wr_en  = w_wr_en;
  assign mem_addr   = r_addr;
  assign mem_wdata  = w_head;
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);
  assign overflow   = r_overflow;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_hs_wb_buffer.sv
// Directed bench for hs_wb_buffer: a per-cycle vector table for the basic,
// wrap, ignored-start and zero-length tiles, then hand sequences for
// backpressure, full-with-pop and reset in DRAIN.
module tb_hs_wb_buffer;

  localparam int DW = 224;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [11:0]     base_addr;
  logic [12:0]     num_words;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            mem_wr_en;
  logic [11:0]     mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [3:0]      fifo_level;
`ifdef HS_WB_DROP_CNT_EN
  logic [15:0]     drop_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  hs_wb_buffer #(
    .OUT_SIZE   (14),
    .LANES      (16),
    .FIFO_DEPTH (8),
    .ADDR_WIDTH (12),
    .CNT_WIDTH  (13)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .fifo_level (fifo_level)
`ifdef HS_WB_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [11:0] base;
    logic [12:0] num;
    logic        iv;
    int          tag;
    logic        rdy;
    logic        e_wr;
    logic [11:0] e_addr;
    int          e_tag;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;
    logic [3:0]  e_lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic st, input logic [11:0] base, input logic [12:0] num,
                             input logic iv, input int tag, input logic rdy,
                             input logic e_wr, input logic [11:0] e_addr, input int e_tag,
                             input logic e_busy, input logic e_done, input logic e_ovf,
                             input logic [3:0] e_lvl);
    vec_t r;
    r.st = st; r.base = base; r.num = num; r.iv = iv; r.tag = tag; r.rdy = rdy;
    r.e_wr = e_wr; r.e_addr = e_addr; r.e_tag = e_tag; r.e_busy = e_busy;
    r.e_done = e_done; r.e_ovf = e_ovf; r.e_lvl = e_lvl;
    return r;
  endfunction

  // Beat payload: lane i carries tag*16+i, so tag 0 gives lane i = i.
  function automatic logic [DW-1:0] mk_data(input int tag);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) d[i*14 +: 14] = 14'(tag*16 + i);
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one tile: beats tagged 1..num on consecutive cycles, mem_ready low
  // until cycle rdy_from. exp_q must hold the tags expected at the write port.
  task automatic tile(input logic [11:0] base, input int num, input int rdy_from,
                      input int exp_done_t, input int exp_drops);
    int t_done;
    logic [11:0] ea;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = 13'(num);
    in_valid = 1'b0; in_data = '0; mem_ready = 1'b0;
    #1 chk("tile_start_busy", 32'(busy), 32'd0);
    ea = base;
    t_done = -1;
    for (int t = 1; t <= 40 && t_done < 0; t++) begin
      @(negedge clk);
      start     = 1'b0;
      in_valid  = (t <= num + 2);
      in_data   = mk_data(t);
      mem_ready = (t >= rdy_from);
      #1;
      if (t <= rdy_from + 1)
        chk("tile_level", 32'(fifo_level), 32'((t - 1 > 8) ? 8 : t - 1));
      if (mem_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("tile_extra_write", 32'(mem_wr_en), 32'd0);
        end else begin
          chk("tile_addr", 32'(mem_addr), 32'(ea));
          chk_data("tile_data", mem_wdata, mk_data(exp_q[0]));
          if (mem_ready) begin
            void'(exp_q.pop_front());
            ea = ea + 12'd1;
          end
        end
      end
      if (done) t_done = t;
    end
    chk("tile_done_cycle", 32'(t_done), 32'(exp_done_t));
    chk("tile_writes_left", 32'(exp_q.size()), 32'd0);
    chk("tile_overflow", 32'(overflow), 32'(exp_drops != 0));
`ifdef HS_WB_DROP_CNT_EN
    chk("tile_drop_count", 32'(drop_count), 32'(exp_drops));
`endif
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("tile_back_idle", 32'({busy, done, mem_wr_en}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    in_valid = 1'b0; in_data = '0; mem_ready = 1'b0;

    //        st  base    num  iv tag rdy | wr  addr   tag busy done ovf lvl
    // basic tile: 4 beats at 0x010
    tbl.push_back(v(1, 12'h010, 4, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 0, 1,   0, 12'h000, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 1, 1,   1, 12'h010, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 1, 2, 1,   1, 12'h011, 1, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 1, 3, 1,   1, 12'h012, 2, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   1, 12'h013, 3, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    // wrap tile at 0xFFE with a start during RUN that must be ignored
    tbl.push_back(v(1, 12'hFFE, 3, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 5, 1,   0, 12'h000, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 12'h100, 1, 1, 6, 1,   1, 12'hFFE, 5, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 1, 7, 1,   1, 12'hFFF, 6, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   1, 12'h000, 7, 1, 0, 0, 1));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    // zero-length tile, then in_valid in IDLE must not be stored
    tbl.push_back(v(1, 12'h055, 0, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 1, 9, 1,   0, 12'h000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 12'h000, 0, 0, 0, 1,   0, 12'h000, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
`ifdef HS_WB_DROP_CNT_EN
    chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      start     = tbl[k].st;
      base_addr = tbl[k].base;
      num_words = tbl[k].num;
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].iv ? mk_data(tbl[k].tag) : '0;
      mem_ready = tbl[k].rdy;
      #1;
      chk($sformatf("vec%0d_wr_en", k), 32'(mem_wr_en), 32'(tbl[k].e_wr));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(tbl[k].e_done));
      chk($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(tbl[k].e_ovf));
      chk($sformatf("vec%0d_level", k), 32'(fifo_level), 32'(tbl[k].e_lvl));
      if (tbl[k].e_wr) begin
        chk($sformatf("vec%0d_addr", k), 32'(mem_addr), 32'(tbl[k].e_addr));
        chk_data($sformatf("vec%0d_data", k), mem_wdata, mk_data(tbl[k].e_tag));
      end
    end
    start = 1'b0; in_valid = 1'b0;

    // Full FIFO meets a pop on the ninth beat: accepted, level stays 8, no overflow.
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
    tile(12'h200, 9, 9, 18, 0);

    // Ten cycles of backpressure: beats 9 and 10 dropped, ten writes, done after them.
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 11, 12};
    tile(12'h300, 12, 11, 21, 2);

    // Reset while draining with three entries queued.
    @(negedge clk);
    start = 1'b1; base_addr = 12'h400; num_words = 13'd3; mem_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = mk_data(t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("drain_level", 32'(fifo_level), 32'd3);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_wr_en", 32'(mem_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_wr_en", 32'(mem_wr_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
